mux21_arb: RTL



---
 rtl/mux21_arb_pkg.sv | 12 +
 rtl/mux21_arb_fsm.sv | 79 +++++++
 rtl/mux21_arb.sv | 50 +++++
 3 files changed

// File: rtl/mux21_arb_pkg.sv
// Shared state encoding and hold-counter width for the 2:1 round-robin arbiter.
package mux21_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    localparam int HCNT_W = 8;

endpackage

// File: rtl/mux21_arb_fsm.sv
// Round-robin grant FSM with per-grant burst limit; grants registered, one edge after request.
// Exposes next-state grants so the select register can switch on the same edge as the grants.
module mux21_arb_fsm
    import mux21_arb_pkg::*;
#(
    parameter int MAXHOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic nxt_gnt0,
    output logic nxt_gnt1
);

    localparam logic [HCNT_W-1:0] HOLD_MAX  = HCNT_W'(MAXHOLD);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAXHOLD - 1);

    state_t              state;
    state_t              nxt_state;
    logic                last;
    logic                nxt_last;
    logic [HCNT_W-1:0]   hcnt;
    logic [HCNT_W-1:0]   nxt_hcnt;
    logic                entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            hcnt  <= '0;
        end else begin
            state <= nxt_state;
            last  <= nxt_last;
            hcnt  <= nxt_hcnt;
        end
    end

    always_comb begin
        nxt_state = state;
        unique case (state)
            IDLE: begin
                if (req0 && req1)  nxt_state = last ? G0 : G1;
                else if (req0)     nxt_state = G0;
                else if (req1)     nxt_state = G1;
            end
            G0: begin
                if (!req0)                          nxt_state = req1 ? G1 : IDLE;
                else if (req1 && hcnt >= HOLD_LAST) nxt_state = G1;
            end
            G1: begin
                if (!req1)                          nxt_state = req0 ? G0 : IDLE;
                else if (req0 && hcnt >= HOLD_LAST) nxt_state = G0;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Uncontended holders keep counting; the counter wraps instead of forcing a release.
    always_comb begin
        nxt_last = last;
        nxt_hcnt = hcnt;
        entry    = (nxt_state != state) && (nxt_state != IDLE);
        if (entry) begin
            nxt_last = (nxt_state == G1);
            nxt_hcnt = '0;
        end else if (state != IDLE) begin
            nxt_hcnt = (hcnt >= HOLD_MAX) ? '0 : hcnt + 1'b1;
        end
    end

    assign gnt0     = (state == G0);
    assign gnt1     = (state == G1);
    assign nxt_gnt0 = (nxt_state == G0);
    assign nxt_gnt1 = (nxt_state == G1);

endmodule

// File: rtl/mux21_arb.sv
// Arbitrated 2:1 mux: GNT/SD one edge after request, Z/ZV one edge after grant.
// Sources are held off by withholding grant; Z holds its value while no grant is active.
module mux21_arb
    import mux21_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAXHOLD = 4
) (
    input  logic             CK,
    input  logic             CDN,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             SD,
    output logic [WIDTH-1:0] Z,
    output logic             ZV
);

    logic nxt_gnt0;
    logic nxt_gnt1;

    mux21_arb_fsm #(.MAXHOLD(MAXHOLD)) u_fsm (
        .clk      (CK),
        .rst_n    (CDN),
        .req0     (REQ0),
        .req1     (REQ1),
        .gnt0     (GNT0),
        .gnt1     (GNT1),
        .nxt_gnt0 (nxt_gnt0),
        .nxt_gnt1 (nxt_gnt1)
    );

    // SD follows the incoming grant so it flips on the same edge as GNT; it holds through IDLE.
    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            SD <= 1'b0;
            Z  <= '0;
            ZV <= 1'b0;
        end else begin
            if (nxt_gnt0)      SD <= 1'b0;
            else if (nxt_gnt1) SD <= 1'b1;
            ZV <= GNT0 | GNT1;
            if (GNT0 | GNT1) Z <= SD ? D1 : D0;
        end
    end

endmodule
